// File: rtl/adaptive_filter_fir_diff.sv
// ---------------------------------------------------------------------------
// adaptive_filter_fir_diff
//
// Pipelined 10-tap antisymmetric FIR differentiator. Takes the signed Q8.6
// sample stream and produces a saturated Q8.12 derivative estimate:
//
//    y[n] = sum_{k=0..4} a_k * (x[n-k] - x[n-9+k])
//
// Pipeline (one register stage each, 4 cycles from sample acceptance):
//    delay line -> pre-add -> multiply/align -> partial sums -> sum+saturate
//
// Ports:
//    clk        system clock, rising edge
//    rst        synchronous active-high reset (clears data and valids)
//    in_valid   in_data carries a new sample; the delay line shifts only then
//    in_data    signed Q8.6 sample
//    out_valid  out_data / out_sat valid this cycle
//    out_data   signed Q8.12 result, clipped to the output range
//    out_sat    out_data was clipped (qualified by out_valid)
// ---------------------------------------------------------------------------
module adaptive_filter_fir_diff #(
   parameter int WORDLENGTH        = 14,
   parameter int FRACTIONAL_LENGTH = 6,
   parameter int OUT_WL            = 20,
   parameter int OUT_FL            = 12,
   parameter int ACC_WL            = 24
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic signed [WORDLENGTH-1:0] in_data,
   output logic                         out_valid,
   output logic signed [OUT_WL-1:0]     out_data,
   output logic                         out_sat
);

   localparam int NTAPS = 10;
   localparam int NPAIR = NTAPS / 2;
   localparam int DW    = WORDLENGTH + 1;   // pre-adder width, exact
   localparam int SW    = ACC_WL + 2;       // final sum width, cannot overflow

   localparam logic signed [OUT_WL-1:0] OUT_MAX = {1'b0, {(OUT_WL-1){1'b1}}};
   localparam logic signed [OUT_WL-1:0] OUT_MIN = {1'b1, {(OUT_WL-1){1'b0}}};

   // Fixed coefficient values (integer codes) and their fractional lengths.
   function automatic logic signed [ACC_WL-1:0] coef(input int k);
      case (k)
         0:       coef = ACC_WL'(-1);    // Q2.6  -0.015625
         1:       coef = ACC_WL'(25);    // Q2.7  +0.1953125
         2:       coef = ACC_WL'(-51);   // Q2.7  -0.3984375
         3:       coef = ACC_WL'(7);     // Q2.4  +0.4375
         4:       coef = ACC_WL'(19);    // Q2.5  +0.59375
         default: coef = '0;
      endcase
   endfunction

   function automatic int coef_fl(input int k);
      case (k)
         0:       coef_fl = 6;
         1:       coef_fl = 7;
         2:       coef_fl = 7;
         3:       coef_fl = 4;
         4:       coef_fl = 5;
         default: coef_fl = 0;
      endcase
   endfunction

   // Registers
   logic signed [WORDLENGTH-1:0] r_x [NTAPS];
   logic signed [DW-1:0]         r_d [NPAIR];
   logic signed [ACC_WL-1:0]     r_p [NPAIR];
   logic signed [ACC_WL-1:0]     r_s0, r_s1, r_s2;
   logic [3:0]                   r_vld;

   // Combinational stage results
   logic signed [DW-1:0]         w_d     [NPAIR];
   logic signed [ACC_WL-1:0]     w_align [NPAIR];
   logic signed [SW-1:0]         w_acc;

   genvar gi;
   generate
      for (gi = 0; gi < NPAIR; gi = gi + 1) begin : g_pair
         // Symmetric tap pair difference; one extra bit makes it exact.
         assign w_d[gi] = DW'(r_x[gi]) - DW'(r_x[NTAPS-1-gi]);

         // Product is d (FL of input) times a_k (FL coef_fl), realigned to
         // OUT_FL. Right shifts are arithmetic, i.e. truncate toward -inf.
         localparam int SH = OUT_FL - (FRACTIONAL_LENGTH + coef_fl(gi));
         logic signed [ACC_WL-1:0] w_full;
         assign w_full = ACC_WL'(r_d[gi]) * coef(gi);
         if (SH >= 0) begin : g_shl
            assign w_align[gi] = w_full <<< SH;
         end else begin : g_shr
            assign w_align[gi] = w_full >>> (-SH);
         end
      end
   endgenerate

   assign w_acc = SW'(r_s0) + SW'(r_s1) + SW'(r_s2);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NTAPS; i++) r_x[i] <= '0;
         for (int i = 0; i < NPAIR; i++) begin
            r_d[i] <= '0;
            r_p[i] <= '0;
         end
         r_s0      <= '0;
         r_s1      <= '0;
         r_s2      <= '0;
         r_vld     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else begin
         r_vld     <= {r_vld[2:0], in_valid};
         out_valid <= r_vld[3];

         // Each stage only advances with its own valid, so data held in the
         // pipeline (and on the outputs) stays put across input gaps.
         if (in_valid) begin
            r_x[0] <= in_data;
            for (int i = 1; i < NTAPS; i++) r_x[i] <= r_x[i-1];
         end
         if (r_vld[0]) begin
            for (int i = 0; i < NPAIR; i++) r_d[i] <= w_d[i];
         end
         if (r_vld[1]) begin
            for (int i = 0; i < NPAIR; i++) r_p[i] <= w_align[i];
         end
         if (r_vld[2]) begin
            r_s0 <= r_p[0] + r_p[1];
            r_s1 <= r_p[2] + r_p[3];
            r_s2 <= r_p[4];
         end
         if (r_vld[3]) begin
            if (w_acc > SW'(OUT_MAX)) begin
               out_data <= OUT_MAX;
               out_sat  <= 1'b1;
            end else if (w_acc < SW'(OUT_MIN)) begin
               out_data <= OUT_MIN;
               out_sat  <= 1'b1;
            end else begin
               out_data <= w_acc[OUT_WL-1:0];
               out_sat  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_adaptive_filter_fir_diff.sv
// ---------------------------------------------------------------------------
// tb_adaptive_filter_fir_diff
//
// Directed-vector bench for adaptive_filter_fir_diff. A monitor records every
// valid output (value, saturation flag, edge index) plus a per-cycle log of
// in_valid/out_valid/out_data; each test task drives its stimulus and checks
// the recorded results against hand-computed values.
// ---------------------------------------------------------------------------
module tb_adaptive_filter_fir_diff;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic signed [13:0] in_data;
   logic               out_valid;
   logic signed [19:0] out_data;
   logic               out_sat;

   always #5 clk = ~clk;

   adaptive_filter_fir_diff dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sat   (out_sat)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   logic               vin_log  [2048];
   logic               vout_log [2048];
   logic signed [19:0] dout_log [2048];

   logic signed [19:0] q_data [$];
   logic               q_sat  [$];
   int                 q_cyc  [$];

   // cyc is the index of the most recent rising edge.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (cyc < 2048) vin_log[cyc] = in_valid && !rst;
   end

   always @(negedge clk) begin
      if (cyc < 2048) begin
         vout_log[cyc] = out_valid;
         dout_log[cyc] = out_data;
      end
      if (out_valid === 1'b1) begin
         q_data.push_back(out_data);
         q_sat.push_back(out_sat);
         q_cyc.push_back(cyc);
      end
   end

   task automatic step(input logic v, input logic signed [13:0] d);
      in_valid = v;
      in_data  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      step(1'b0, 14'sd0);
      step(1'b0, 14'sd0);
      rst = 1'b0;
   endtask

   task automatic clear_q();
      q_data.delete();
      q_sat.delete();
      q_cyc.delete();
   endtask

   task automatic drain();
      repeat (8) step(1'b0, 14'sd0);
   endtask

   // -----------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1;
      step(1'b1, 14'sd64);
      step(1'b1, 14'sd64);
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL reset_valid: got %b expected 0", out_valid);
      end
      n_vec++;
      if (out_data !== 20'sd0) begin
         n_err++; $display("FAIL reset_data: got %0d expected 0", out_data);
      end
      n_vec++;
      if (out_sat !== 1'b0) begin
         n_err++; $display("FAIL reset_sat: got %b expected 0", out_sat);
      end
      rst = 1'b0;
      clear_q();
      drain();
      n_vec++;
      if (q_data.size() != 0) begin
         n_err++; $display("FAIL reset_ignored_input: got %0d outputs expected 0", q_data.size());
      end
      $display("test_reset done");
   endtask

   // -----------------------------------------------------------------------
   task automatic test_impulse();
      int exp_v [12] = '{-64, 800, -1632, 1792, 2432, -2432, -1792, 1632, -800, 64, 0, 0};
      int t0;
      logic signed [19:0] e;
      apply_reset();
      clear_q();
      step(1'b1, 14'sh0040);
      t0 = cyc;
      repeat (11) step(1'b1, 14'sd0);
      drain();
      n_vec++;
      if (q_data.size() != 12) begin
         n_err++; $display("FAIL impulse_count: got %0d expected 12", q_data.size());
      end else begin
         n_vec++;
         if (q_cyc[0] != t0 + 4) begin
            n_err++; $display("FAIL impulse_latency: got edge %0d expected %0d", q_cyc[0], t0 + 4);
         end
         for (int i = 0; i < 12; i++) begin
            e = 20'(exp_v[i]);
            n_vec++;
            if (q_data[i] !== e || q_sat[i] !== 1'b0) begin
               n_err++;
               $display("FAIL impulse_out[%0d]: got %0d sat %b expected %0d sat 0", i, q_data[i], q_sat[i], e);
            end
            n_vec++;
            if (q_cyc[i] != q_cyc[0] + i) begin
               n_err++; $display("FAIL back_to_back[%0d]: got edge %0d expected %0d", i, q_cyc[i], q_cyc[0] + i);
            end
         end
      end
      $display("test_impulse done");
   endtask

   // -----------------------------------------------------------------------
   task automatic test_dc();
      apply_reset();
      clear_q();
      repeat (20) step(1'b1, 14'sh0640);
      drain();
      n_vec++;
      if (q_data.size() != 20) begin
         n_err++; $display("FAIL dc_count: got %0d expected 20", q_data.size());
      end else begin
         n_vec++;
         if (q_data[0] !== -20'sd1600) begin
            n_err++; $display("FAIL dc_first: got %0d expected -1600", q_data[0]);
         end
         for (int i = 9; i < 20; i++) begin
            n_vec++;
            if (q_data[i] !== 20'sd0 || q_sat[i] !== 1'b0) begin
               n_err++; $display("FAIL dc_out[%0d]: got %0d sat %b expected 0 sat 0", i, q_data[i], q_sat[i]);
            end
         end
      end
      $display("test_dc done");
   endtask

   // -----------------------------------------------------------------------
   task automatic test_saturation(input logic inv);
      logic signed [13:0] codes [10] = '{14'sd8191, -14'sd8192, 14'sd8191, -14'sd8192, -14'sd8192,
                                         14'sd8191, 14'sd8191, -14'sd8192, 14'sd8191, -14'sd8192};
      logic signed [19:0] e;
      e = inv ? 20'sh80000 : 20'sh7FFFF;
      apply_reset();
      clear_q();
      // Bitwise inversion maps +8191 <-> -8192, i.e. the sign-inverted stream.
      for (int i = 0; i < 10; i++) step(1'b1, inv ? ~codes[i] : codes[i]);
      drain();
      n_vec++;
      if (q_data.size() != 10) begin
         n_err++; $display("FAIL sat_count(inv=%0b): got %0d expected 10", inv, q_data.size());
      end else begin
         n_vec++;
         if (q_data[9] !== e || q_sat[9] !== 1'b1) begin
            n_err++;
            $display("FAIL sat_out(inv=%0b): got %h sat %b expected %h sat 1", inv, q_data[9], q_sat[9], e);
         end
      end
      $display("test_saturation inv=%0b done", inv);
   endtask

   // -----------------------------------------------------------------------
   task automatic test_gaps();
      int exp_v [12] = '{-64, 800, -1632, 1792, 2432, -2432, -1792, 1632, -800, 64, 0, 0};
      int c_start, c_end;
      logic seen;
      logic signed [19:0] e;
      apply_reset();
      clear_q();
      c_start = cyc;
      for (int i = 0; i < 12; i++) begin
         step(1'b1, (i == 0) ? 14'sh0040 : 14'sd0);
         step(1'b0, 14'sd0);
         step(1'b0, 14'sd0);
      end
      drain();
      c_end = cyc;
      n_vec++;
      if (q_data.size() != 12) begin
         n_err++; $display("FAIL gaps_count: got %0d expected 12", q_data.size());
      end else begin
         for (int i = 0; i < 12; i++) begin
            e = 20'(exp_v[i]);
            n_vec++;
            if (q_data[i] !== e) begin
               n_err++; $display("FAIL gaps_out[%0d]: got %0d expected %0d", i, q_data[i], e);
            end
         end
      end
      seen = 1'b0;
      for (int c = c_start + 4; c <= c_end; c++) begin
         n_vec++;
         if (vout_log[c] !== vin_log[c-4]) begin
            n_err++; $display("FAIL gaps_valid@%0d: got %b expected %b", c, vout_log[c], vin_log[c-4]);
         end
         if (seen && vout_log[c] === 1'b0) begin
            n_vec++;
            if (dout_log[c] !== dout_log[c-1]) begin
               n_err++; $display("FAIL gaps_hold@%0d: got %0d expected %0d", c, dout_log[c], dout_log[c-1]);
            end
         end
         if (vout_log[c] === 1'b1) seen = 1'b1;
      end
      $display("test_gaps done");
   endtask

   // -----------------------------------------------------------------------
   task automatic test_truncation();
      int exp_v [10] = '{-1, 12, -26, 28, 38, -38, -28, 25, -13, 1};
      logic signed [19:0] e;
      apply_reset();
      clear_q();
      step(1'b1, 14'sh0001);
      repeat (11) step(1'b1, 14'sd0);
      drain();
      n_vec++;
      if (q_data.size() != 12) begin
         n_err++; $display("FAIL trunc_count: got %0d expected 12", q_data.size());
      end else begin
         for (int i = 0; i < 10; i++) begin
            e = 20'(exp_v[i]);
            n_vec++;
            if (q_data[i] !== e) begin
               n_err++; $display("FAIL trunc_out[%0d]: got %0d expected %0d", i, q_data[i], e);
            end
         end
      end
      $display("test_truncation done");
   endtask

   // -----------------------------------------------------------------------
   task automatic test_mid_reset();
      int t0;
      apply_reset();
      clear_q();
      step(1'b1, 14'sh0040);
      step(1'b1, 14'sd0);
      step(1'b1, 14'sd0);
      // Reset with a live sample on the input; it must be ignored.
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = 14'sh0040;
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0 || out_data !== 20'sd0) begin
         n_err++; $display("FAIL midrst_during: got valid %b data %0d expected 0 0", out_valid, out_data);
      end
      rst = 1'b0;
      step(1'b1, 14'sd0);
      t0 = cyc;
      repeat (11) step(1'b1, 14'sd0);
      drain();
      n_vec++;
      if (q_data.size() != 12) begin
         n_err++; $display("FAIL midrst_count: got %0d expected 12", q_data.size());
      end else begin
         n_vec++;
         if (q_cyc[0] != t0 + 4) begin
            n_err++; $display("FAIL midrst_first: got edge %0d expected %0d", q_cyc[0], t0 + 4);
         end
         for (int i = 0; i < 12; i++) begin
            n_vec++;
            if (q_data[i] !== 20'sd0) begin
               n_err++; $display("FAIL midrst_out[%0d]: got %0d expected 0", i, q_data[i]);
            end
         end
      end
      $display("test_mid_reset done");
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      test_reset();
      test_impulse();
      test_dc();
      test_saturation(1'b0);
      test_saturation(1'b1);
      test_gaps();
      test_truncation();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
